q_tsbus_drv_seq: RTL and testbench

Sequencer that sits directly upstream of the Q_RBUFZP weak tri-state buffers on a shared single-bit emulated bus. It arbitrates among N_DRV agents, produces registered, at-most-one-hot OE and A for each buffer instance, and enforces turnaround cycles between owners. It also keeps a bus-keeper copy of the last driven value and flags read-back contention on the resolved net.

---
 rtl/q_tsbus_pkg.sv | 18 +
 rtl/q_rr_pick.sv | 30 +++
 rtl/q_tsbus_drv_seq.sv | 115 +++++++++++
 tb/tb_q_tsbus_drv_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/q_tsbus_pkg.sv
// Shared types and sizing helpers for the tri-state bus driver sequencers.
package q_tsbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Counter widths cover the full legal TA_CYC (1..15) and MAX_HOLD (1..255) ranges.
  localparam int TA_W   = 4;
  localparam int HOLD_W = 8;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/q_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module q_rr_pick
  import q_tsbus_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = owner_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/q_tsbus_drv_seq.sv
// Bus-owner sequencer for a shared single-bit emulated tri-state net: arbitration,
// registered OE/A, turnaround gaps, bus keeper and sticky read-back contention flag.
module q_tsbus_drv_seq
  import q_tsbus_pkg::*;
#(
  parameter  int N_DRV    = 4,
  parameter  int TA_CYC   = 1,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = owner_w(N_DRV)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_DRV-1:0] REQ,
  input  logic [N_DRV-1:0] DIN,
  input  logic             BUS,
  output logic [N_DRV-1:0] OE,
  output logic [N_DRV-1:0] A,
  output logic [OW-1:0]    OWNER,
  output logic             BUSY,
  output logic             KEEP,
  output logic             CONTEND
);

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [HOLD_W-1:0] hold;
  logic [TA_W-1:0] ta;

  logic            pick_valid;
  logic [OW-1:0]   pick_idx;
  logic            others;
  logic            own_req;
  logic [HOLD_W-1:0] hold_nxt;

  function automatic logic [N_DRV-1:0] onehot(input logic [OW-1:0] i);
    logic [N_DRV-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] i);
    return (int'(i) == N_DRV - 1) ? '0 : i + OW'(1);
  endfunction

  function automatic logic [HOLD_W-1:0] hold_sat(input logic [HOLD_W-1:0] h);
    return (h == HOLD_W'(MAX_HOLD)) ? h : h + HOLD_W'(1);
  endfunction

  q_rr_pick #(.N(N_DRV)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    others   = |(REQ & ~onehot(OWNER));
    own_req  = REQ[OWNER];
    hold_nxt = hold_sat(hold);
  end

  // hold_nxt counts the cycle ending at this edge, so the owner gets exactly MAX_HOLD contested cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      OE      <= '0;
      A       <= '0;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      KEEP    <= 1'b0;
      CONTEND <= 1'b0;
      ptr     <= '0;
      hold    <= '0;
      ta      <= '0;
    end else begin
      if (|OE) begin
        KEEP <= BUS;
        if (BUS != A[OWNER]) CONTEND <= 1'b1;
      end

      case (state)
        DRIVE: begin
          if (!own_req || (others && hold_nxt == HOLD_W'(MAX_HOLD))) begin
            state <= TURN;
            OE    <= '0;
            A     <= '0;
            BUSY  <= 1'b0;
            hold  <= '0;
            ta    <= '0;
          end else begin
            A    <= onehot(OWNER) & {N_DRV{DIN[OWNER]}};
            hold <= others ? hold_nxt : '0;
          end
        end
        default: begin
          if (state == TURN && ta != TA_W'(TA_CYC - 1)) begin
            ta <= ta + TA_W'(1);
          end else if (pick_valid) begin
            state <= DRIVE;
            OE    <= onehot(pick_idx);
            A     <= onehot(pick_idx) & {N_DRV{DIN[pick_idx]}};
            OWNER <= pick_idx;
            ptr   <= next_ptr(pick_idx);
            BUSY  <= 1'b1;
            hold  <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_tsbus_drv_seq.sv
// Directed bench for q_tsbus_drv_seq with N_DRV=4, TA_CYC=1, MAX_HOLD=8.
module tb_q_tsbus_drv_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] DIN;
  logic       bus;
  logic [3:0] OE;
  logic [3:0] A;
  logic [1:0] OWNER;
  logic       BUSY;
  logic       KEEP;
  logic       CONTEND;

  logic       force_en;
  logic       force_val;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  // Buffer model: the owner's A drives the net, a weak pull-up holds it at 1 when floating.
  always_comb begin
    if (force_en)    bus = force_val;
    else if (|OE)    bus = |(OE & A);
    else             bus = 1'b1;
  end

  q_tsbus_drv_seq #(.N_DRV(4), .TA_CYC(1), .MAX_HOLD(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .DIN     (DIN),
    .BUS     (bus),
    .OE      (OE),
    .A       (A),
    .OWNER   (OWNER),
    .BUSY    (BUSY),
    .KEEP    (KEEP),
    .CONTEND (CONTEND)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST       = 1'b1;
    REQ       = 4'b1111;
    DIN       = 4'b1111;
    force_en  = 1'b0;
    force_val = 1'b0;
    repeat (3) step();

    chk("rst_oe", 32'(OE), 32'h0);
    chk("rst_a", 32'(A), 32'h0);
    chk("rst_owner", 32'(OWNER), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_keep", 32'(KEEP), 32'h0);
    chk("rst_contend", 32'(CONTEND), 32'h0);

    // All four requesting from reset: pointer order 0,1,2,3,0 with forced releases.
    RST = 1'b0;
    step();
    chk("rr0_oe", 32'(OE), 32'h1);
    chk("rr0_a", 32'(A), 32'h1);
    chk("rr0_busy", 32'(BUSY), 32'h1);
    repeat (7) step();
    chk("rr0_hold_oe", 32'(OE), 32'h1);
    chk("rr0_keep", 32'(KEEP), 32'h1);
    step();
    chk("rr0_turn_oe", 32'(OE), 32'h0);
    chk("rr0_turn_busy", 32'(BUSY), 32'h0);
    step();
    chk("rr1_oe", 32'(OE), 32'h2);
    chk("rr1_owner", 32'(OWNER), 32'h1);
    repeat (8) step();
    chk("rr1_turn_oe", 32'(OE), 32'h0);
    step();
    chk("rr2_oe", 32'(OE), 32'h4);
    repeat (9) step();
    chk("rr3_oe", 32'(OE), 32'h8);
    chk("rr3_owner", 32'(OWNER), 32'h3);
    repeat (9) step();
    chk("rr4_oe", 32'(OE), 32'h1);
    chk("rr_contend", 32'(CONTEND), 32'h0);

    REQ = 4'b0000;
    step();
    chk("rel_oe", 32'(OE), 32'h0);
    step();
    chk("idle_oe", 32'(OE), 32'h0);
    chk("idle_busy", 32'(BUSY), 32'h0);

    // Single agent 2, DIN[2] = 1,0,1,1,0 on consecutive edges.
    REQ = 4'b0100;
    DIN = 4'b0100;
    step();
    chk("s2_oe", 32'(OE), 32'h4);
    chk("s2_owner", 32'(OWNER), 32'h2);
    chk("s2_a0", 32'(A), 32'h4);
    chk("s2_bus0", 32'(bus), 32'h1);
    DIN = 4'b1011;
    step();
    chk("s2_a1", 32'(A), 32'h0);
    chk("s2_bus1", 32'(bus), 32'h0);
    chk("s2_keep1", 32'(KEEP), 32'h1);
    DIN = 4'b0100;
    step();
    chk("s2_a2", 32'(A), 32'h4);
    chk("s2_keep2", 32'(KEEP), 32'h0);
    step();
    chk("s2_a3", 32'(A), 32'h4);
    chk("s2_keep3", 32'(KEEP), 32'h1);
    DIN = 4'b0000;
    step();
    chk("s2_a4", 32'(A), 32'h0);
    chk("s2_bus4", 32'(bus), 32'h0);
    REQ = 4'b0000;
    step();
    chk("s2_rel_oe", 32'(OE), 32'h0);
    chk("s2_rel_a", 32'(A), 32'h0);
    chk("s2_rel_keep", 32'(KEEP), 32'h0);
    repeat (2) step();
    chk("s2_idle_bus", 32'(bus), 32'h1);
    chk("s2_idle_keep", 32'(KEEP), 32'h0);

    // Fairness: agent 0 holds, agent 1 waits; pointer is 3 so agent 0 wins first.
    REQ = 4'b0011;
    DIN = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("fair_oe0_%0d", i), 32'(OE), 32'h1);
    end
    step();
    chk("fair_turn", 32'(OE), 32'h0);
    step();
    chk("fair_oe1", 32'(OE), 32'h2);
    chk("fair_owner1", 32'(OWNER), 32'h1);
    REQ = 4'b0000;
    repeat (2) step();
    chk("fair_idle", 32'(OE), 32'h0);

    // Contention: agent 3 drives 1 while the net is pulled to 0.
    REQ = 4'b1000;
    DIN = 4'b1000;
    step();
    chk("ct_oe", 32'(OE), 32'h8);
    chk("ct_a", 32'(A), 32'h8);
    chk("ct_pre", 32'(CONTEND), 32'h0);
    force_en  = 1'b1;
    force_val = 1'b0;
    step();
    chk("ct_set", 32'(CONTEND), 32'h1);
    chk("ct_keep", 32'(KEEP), 32'h0);
    force_en = 1'b0;
    step();
    chk("ct_sticky1", 32'(CONTEND), 32'h1);
    chk("ct_keep2", 32'(KEEP), 32'h1);
    step();
    chk("ct_sticky2", 32'(CONTEND), 32'h1);
    chk("ct_oe2", 32'(OE), 32'h8);

    // Asynchronous reset between edges while agent 3 drives.
    #3;
    RST = 1'b1;
    #1;
    chk("ar_oe", 32'(OE), 32'h0);
    chk("ar_a", 32'(A), 32'h0);
    chk("ar_busy", 32'(BUSY), 32'h0);
    chk("ar_contend", 32'(CONTEND), 32'h0);
    REQ = 4'b1111;
    DIN = 4'b0000;
    step();
    RST = 1'b0;
    chk("ar_hold_oe", 32'(OE), 32'h0);
    step();
    chk("ar_first_oe", 32'(OE), 32'h1);
    chk("ar_first_owner", 32'(OWNER), 32'h0);

    // Random soak: structural invariants every cycle.
    for (int i = 0; i < 10000; i++) begin
      REQ = 4'($urandom);
      DIN = 4'($urandom);
      step();
      chk("rnd_onehot", 32'($onehot0(OE)), 32'h1);
      chk("rnd_a_in_oe", 32'(A & ~OE), 32'h0);
      chk("rnd_busy", 32'(BUSY), 32'(|OE));
    end
    chk("rnd_contend", 32'(CONTEND), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
